mul_share_arbiter: RTL and testbench

- Shares one registered 8x8 unsigned multiplier between NREQ requesters.
- Each requester uses a valid/ready request channel.
- Arbitration is round-robin; one operation is in flight at a time.
- The result returns on a single response channel, tagged with the requester id. The block sits between user logic and the multiplier datapath in the tile top.

---
 rtl/mul_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_mul_share_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Shares one registered unsigned multiplier between NREQ valid/ready requesters.
// Requesters are picked round-robin, and only one operation is in flight at a time.
// The result comes back on one response channel, tagged with the requester id.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     per-requester request valid            [NREQ]
//   req_ready     per-requester grant, one-hot or zero   [NREQ]
//   req_a, req_b  packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid     result valid (RESP state)
//   rsp_ready     consumer accepts result
//   rsp_id        requester index of the result          [IDW]
//   rsp_product   unsigned a*b                           [2*WIDTH]
//   busy          FSM not in IDLE
module mul_share_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned IDW   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [IDW-1:0]          rsp_id,
   output logic [2*WIDTH-1:0]      rsp_product,
   output logic                    busy
);

   localparam int unsigned PW = 2 * WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [IDW-1:0]   r_rr_ptr;
   logic [IDW-1:0]   r_id;
   logic [IDW-1:0]   r_rsp_id;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [PW-1:0]    r_product;

   logic [IDW-1:0]   w_win;
   logic             w_found;
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic             w_req_hs;
   logic             w_rsp_hs;

   // Round-robin winner. The first pass covers indices at or above the
   // pointer. The second pass wraps to the bottom, so it can only pick an
   // index below the pointer.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!w_found && req_valid[i] && (32'(r_rr_ptr) <= i)) begin
            w_found = 1'b1;
            w_win   = IDW'(i);
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!w_found && req_valid[i]) begin
            w_found = 1'b1;
            w_win   = IDW'(i);
         end
      end
   end

   // Operand mux and one-hot grant for the winner
   always_comb begin
      w_sel_a   = '0;
      w_sel_b   = '0;
      req_ready = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (w_win == IDW'(i)) begin
            w_sel_a      = req_a[i*WIDTH +: WIDTH];
            w_sel_b      = req_b[i*WIDTH +: WIDTH];
            req_ready[i] = (r_state == S_IDLE) && w_found;
         end
      end
   end

   assign w_req_hs = |(req_valid & req_ready);
   assign w_rsp_hs = (r_state == S_RESP) && rsp_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_req_hs) w_state_nxt = S_CALC;
         S_CALC:  w_state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, multiply, and round-robin pointer update.
   // The product is not cleared on the response handshake; it holds
   // until the next CALC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a       <= '0;
         r_b       <= '0;
         r_id      <= '0;
         r_rsp_id  <= '0;
         r_product <= '0;
         r_rr_ptr  <= '0;
      end else begin
         if (w_req_hs) begin
            r_a  <= w_sel_a;
            r_b  <= w_sel_b;
            r_id <= w_win;
         end
         if (r_state == S_CALC) begin
            r_product <= PW'(r_a) * PW'(r_b);
            r_rsp_id  <= r_id;
         end
         if (w_rsp_hs) begin
            r_rr_ptr <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);
         end
      end
   end

   assign rsp_valid   = (r_state == S_RESP);
   assign busy        = (r_state != S_IDLE);
   assign rsp_id      = r_rsp_id;
   assign rsp_product = r_product;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter (NREQ=4, WIDTH=8).
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_mul_share_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [2*WIDTH-1:0]    rsp_product;
   logic                  busy;

   int checks = 0;
   int errors = 0;

   mul_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
      req_valid[i]            = 1'b1;
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Drives one operation from the grant cycle (IDLE) through the response
   // handshake. rsp_ready is held low for 'hold' RESP cycles. When 'drop' is
   // set, the granted requester withdraws after its handshake.
   task automatic run_op(input int exp_id, input logic [15:0] exp_prod,
                         input int hold, input bit drop);
      rsp_ready = (hold == 0);
      @(negedge clk);
      check("grant", 32'(req_ready), 32'(1) << exp_id);
      check("idle_busy", 32'(busy), 32'd0);
      step();
      if (drop) req_valid[exp_id] = 1'b0;
      @(negedge clk);
      check("calc_ready", 32'(req_ready), 32'd0);
      check("calc_valid", 32'(rsp_valid), 32'd0);
      check("calc_busy", 32'(busy), 32'd1);
      step();
      for (int h = 0; h <= hold; h++) begin
         rsp_ready = (h == hold);
         @(negedge clk);
         check("rsp_valid", 32'(rsp_valid), 32'd1);
         check("rsp_id", 32'(rsp_id), 32'(exp_id));
         check("rsp_product", 32'(rsp_product), 32'(exp_prod));
         check("resp_ready", 32'(req_ready), 32'd0);
         step();
      end
   endtask

   logic [7:0]  ta [NREQ];
   logic [7:0]  tb [NREQ];
   logic [15:0] tp [NREQ];

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;

      // Reset values
      step();
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_product", 32'(rsp_product), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      step();
      rst_n = 1'b1;

      // Idle with no requests for 10 cycles
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("idle_ready", 32'(req_ready), 32'd0);
         check("idle_valid", 32'(rsp_valid), 32'd0);
         check("idle_busy10", 32'(busy), 32'd0);
         step();
      end

      // Single request: 12*13 = 156
      set_req(0, 8'd12, 8'd13);
      run_op(0, 16'd156, 0, 1'b1);
      @(negedge clk);
      check("single_busy_t3", 32'(busy), 32'd0);
      check("single_valid_t3", 32'(rsp_valid), 32'd0);
      check("single_prod_held", 32'(rsp_product), 32'd156);
      step();

      // All four requesters valid continuously, starting from pointer 0
      do_reset();
      ta[0] = 8'd12;  tb[0] = 8'd13;  tp[0] = 16'd156;
      ta[1] = 8'd200; tb[1] = 8'd100; tp[1] = 16'd20000;
      ta[2] = 8'd255; tb[2] = 8'd255; tp[2] = 16'hFE01;
      ta[3] = 8'd0;   tb[3] = 8'd77;  tp[3] = 16'd0;
      for (int i = 0; i < NREQ; i++) set_req(i, ta[i], tb[i]);
      for (int k = 0; k < 6; k++) run_op(k % NREQ, tp[k % NREQ], 0, 1'b0);
      req_valid = '0;

      // Backpressure: 255*255 from req2 (pointer is now 2), held 5 cycles
      // while req0 waits. req0 is granted right after the handshake.
      set_req(2, 8'd255, 8'd255);
      set_req(0, 8'd3, 8'd5);
      run_op(2, 16'hFE01, 5, 1'b1);
      run_op(0, 16'd15, 0, 1'b1);

      // Pointer wrap: serving req3 brings the pointer back to 0
      set_req(3, 8'd9, 8'd9);
      run_op(3, 16'd81, 0, 1'b1);
      set_req(3, 8'd4, 8'd4);
      set_req(0, 8'd2, 8'd50);
      run_op(0, 16'd100, 0, 1'b1);
      run_op(3, 16'd16, 0, 1'b1);

      // Reset one cycle after a req1 handshake discards the operation
      set_req(1, 8'd20, 8'd20);
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rst_mid_grant", 32'(req_ready), 32'b0010);
      step();
      req_valid = '0;
      rst_n     = 1'b0;
      @(negedge clk);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_valid", 32'(rsp_valid), 32'd0);
      check("rst_mid_product", 32'(rsp_product), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("post_rst_valid", 32'(rsp_valid), 32'd0);
         check("post_rst_busy", 32'(busy), 32'd0);
         step();
      end
      set_req(1, 8'd7, 8'd0);
      run_op(1, 16'd0, 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
